crypto_frame_ctrl: RTL and testbench
====================================

# crypto_frame_ctrl

Frame-level sequencer that streams bytes through the existing `encrypt` or `decrypt` cores and folds every ciphertext byte through the `hash` core into a running 8-bit digest. It sits between a byte source and a byte sink and uses valid/ready handshakes on both sides. A digest is emitted once per frame, after the frame's final output byte. This is the first clocked block around the combinational crypto datapath.

## Interface
- `SEED`, default 8'h00: digest accumulator value at the start of each frame.
- `MAX_LEN`, default 256: maximum bytes per frame, range 1..65535. The byte that reaches this count is forced to be the last byte.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `mode`, input, 1: 0 means encrypt, 1 means decrypt. Sampled only on the first accepted byte of a frame.
- `in_valid`, input, 1: input byte valid.
- `in_ready`, output, 1: controller can accept an input byte.
- `in_data`, input, 8: input byte.
- `in_last`, input, 1: marks the final byte of the frame.
- `out_valid`, output, 1: output byte valid.
- `out_ready`, input, 1: sink accepts the output byte.
- `out_data`, output, 8: the transformed byte.
- `out_last`, output, 1: marks the final output byte of the frame.
- `dig_valid`, output, 1: digest is available.
- `dig_ready`, input, 1: digest consumer accepts it.
- `digest`, output, 8: the frame digest.
- `dig_trunc`, output, 1: the frame was cut at `MAX_LEN`. Valid while `dig_valid` is high.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: waiting for the first byte of a frame.
  - STREAM: a frame is in progress.
  - DIGEST: all bytes accepted, waiting to output the digest.
- Reset values: state is IDLE.
  - All valids are 0.
  - `out_data`, `out_last`, `digest` and `dig_trunc` are 0.
  - The accumulator holds `SEED` and the byte count is 0.
- Per-byte data path:
  - Transformed byte: `encrypt(in_data)` when the mode is 0, otherwise `decrypt(in_data)`.
  - Ciphertext byte `c`: `encrypt(in_data)` when the mode is 0, otherwise `in_data`. The hash input is always ciphertext.
  - On each accepted byte: `acc <= {acc[6:0], acc[7]} ^ hash(c)`.
- IDLE, on an accepted byte:
  - Latch `mode` into `mode_q`.
  - The update uses the seed as the previous value: `acc <= {SEED[6:0], SEED[7]} ^ hash(c)`. Set the count to 1.
  - If the byte is the last one, go to DIGEST. Otherwise go to STREAM.
- STREAM, on an accepted byte:
  - Increment the count.
  - The byte is last when `in_last` is high or the count reaches `MAX_LEN`.
  - On the last byte, go to DIGEST. Set `dig_trunc` to `(count==MAX_LEN && !in_last)`.
- DIGEST:
  - `in_ready` is 0.
  - `dig_valid` is `!out_valid`, so the digest never precedes the last data byte.
  - On the `dig_valid && dig_ready` handshake: clear the count, reset the accumulator to `SEED`, go to IDLE.
- Changes to `mode` during a frame are ignored.

## Timing
- Output stage: a single register.
  - In IDLE and STREAM: `in_ready = !out_valid || out_ready`.
  - An accepted byte appears on `out_data` on the next cycle, so latency is 1.
  - Full throughput is 1 byte/cycle while `out_ready` stays high.
- Output holding: `out_valid`, `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
  - Back-pressure propagates to `in_ready` in the same cycle, with a combinational path from `out_ready` to `in_ready`.
- Digest holding: `dig_valid` stays high and `digest` stays stable until `dig_ready`.
  - Earliest `dig_valid`: the cycle after the last output beat is accepted.
  - Simultaneous `out_ready` on the last byte: `dig_valid` rises on the following cycle.
- Next frame: the earliest first byte is accepted the cycle after the digest handshake. `in_ready` in IDLE is 1 once the output register is empty.
- Truncation: with `MAX_LEN=1`, every frame is one byte and `dig_trunc` equals `!in_last`.
- Reset mid-frame: all state clears immediately and any partial digest is discarded. The first post-reset byte starts a new frame.
- Count width: 16 bits. It never wraps, because `MAX_LEN` forces the last byte.

## Structure
- Shared package `crypto_pkg` holds:
  - the state enum {IDLE, STREAM, DIGEST};
  - `MODE_ENC=1'b0` and `MODE_DEC=1'b1`;
  - a function `dig_step(acc, h)` implementing rotate-left-1 then xor.
- Natural sub-module: `crypto_byte_path`. It is combinational, wraps one `encrypt`, one `decrypt` and one `hash` instance, and produces `xform` and `hash(c)` from `din` and the mode.
- The controller contains the FSM, output register, accumulator and count.

## Test plan
- Encrypt a 3-byte frame {8'h00, 8'h5A, 8'hFF} with `out_ready` held at 1.
  - `out_data` equals `encrypt()` of each byte, each 1 cycle after acceptance, with `out_last` on the third.
  - The digest matches a golden fold from `SEED`, and `dig_trunc` is 0.
- Decrypt a 1-byte frame 8'hA5 with `in_last` high.
  - `out_data` is `decrypt(8'hA5)`.
  - `digest` is `{SEED[6:0],SEED[7]} ^ hash(8'hA5)`.
  - Round trip: feed `out_data` through an encrypt frame and confirm the output is 8'hA5 and the digest is identical.
- Back-pressure: hold `out_ready` low for 4 cycles mid-frame.
  - `in_ready` is 0, `out_data` is stable, and no byte is lost or duplicated.
  - `dig_valid` stays 0 until the last byte is consumed.
- With `MAX_LEN=4`, send 6 bytes with no `in_last`.
  - Frame 1 is 4 bytes, `out_last` is on byte 4, and `dig_trunc` is 1.
  - Frame 2 is the remaining 2 bytes.
- Toggle `mode` mid-frame: the output stays in the latched mode. `busy` is high from the first acceptance through the digest handshake.
- Assert `rst` during STREAM after 2 bytes.
  - All outputs return to 0 and the state is IDLE.
  - The next frame {8'h11} yields the single-byte digest, unaffected by the aborted bytes.

Source files
------------

// File: rtl/crypto_pkg.sv
// crypto_pkg
// Shared definitions for the crypto frame controller slice:
//   state_t  : frame sequencer states (IDLE, STREAM, DIGEST)
//   MODE_ENC : mode value selecting the encrypt core
//   MODE_DEC : mode value selecting the decrypt core
//   dig_step : one digest fold step, rotate-left-1 then xor with the hash byte
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DIGEST = 2'd2
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic logic [7:0] dig_step(input logic [7:0] acc, input logic [7:0] h);
    return {acc[6:0], acc[7]} ^ h;
  endfunction

endpackage

// File: rtl/crypto_byte_path.sv
// crypto_byte_path
// Combinational per-byte datapath around one encrypt, one decrypt and one hash core.
//   din    [7:0] in  : byte from the source
//   mode         in  : MODE_ENC or MODE_DEC
//   xform  [7:0] out : encrypt(din) or decrypt(din) depending on mode
//   hash_c [7:0] out : hash of the ciphertext view of the byte
module crypto_byte_path (
  input  logic [7:0] din,
  input  logic       mode,
  output logic [7:0] xform,
  output logic [7:0] hash_c
);
  import crypto_pkg::*;

  logic [7:0] enc_s;
  logic [7:0] dec_s;
  logic [7:0] cipher_s;

  encrypt u_encrypt (.din(din),      .dout(enc_s));
  decrypt u_decrypt (.din(din),      .dout(dec_s));
  hash    u_hash    (.din(cipher_s), .dout(hash_c));

  // The digest always covers ciphertext: in decrypt mode the input already is ciphertext.
  assign cipher_s = (mode == MODE_ENC) ? enc_s : din;
  assign xform    = (mode == MODE_ENC) ? enc_s : dec_s;

endmodule

// File: rtl/crypto_cores.sv
// Combinational byte cores used by the frame controller.
//   encrypt : din -> dout, xor with a fixed key then rotate left by 3
//   decrypt : exact inverse of encrypt
//   hash    : non-linear byte mix (xor with a constant plus nibble swap, 8-bit add)
// Ports of each core: din [7:0] in, dout [7:0] out.
module encrypt (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] t_s;
  assign t_s  = din ^ 8'h3C;
  assign dout = {t_s[4:0], t_s[7:5]};
endmodule

module decrypt (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] t_s;
  // Undo the rotate first, then remove the key.
  assign t_s  = {din[2:0], din[7:3]};
  assign dout = t_s ^ 8'h3C;
endmodule

module hash (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = (din ^ 8'hA7) + {din[3:0], din[7:4]};
endmodule

// File: rtl/crypto_frame_ctrl.sv
// crypto_frame_ctrl
// Frame sequencer: streams bytes through the encrypt/decrypt cores with a one-deep
// output register and folds each ciphertext byte into a per-frame 8-bit digest.
//   clk, rst                    : clock, asynchronous active-high reset
//   mode                        : 0 encrypt, 1 decrypt, latched on a frame's first byte
//   in_valid/in_ready/in_data/in_last     : input byte stream
//   out_valid/out_ready/out_data/out_last : transformed byte stream
//   dig_valid/dig_ready/digest/dig_trunc  : per-frame digest, truncation flag
//   busy                        : frame in progress or digest pending
module crypto_frame_ctrl #(
  parameter logic [7:0] SEED    = 8'h00,
  parameter int         MAX_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       dig_valid,
  input  logic       dig_ready,
  output logic [7:0] digest,
  output logic       dig_trunc,
  output logic       busy
);
  import crypto_pkg::*;

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  state_t      state_r, state_nxt_s;
  logic        mode_r;
  logic        out_valid_r, out_last_r;
  logic [7:0]  out_data_r;
  logic [7:0]  acc_r, digest_r;
  logic        trunc_r;
  logic [15:0] cnt_r;

  logic        mode_eff_s;
  logic [7:0]  xform_s, hash_s;
  logic [15:0] cnt_nxt_s;
  logic [7:0]  acc_prev_s, acc_nxt_s;
  logic        last_s, trunc_s;
  logic        in_ready_s, accept_s, dig_valid_s, dig_hs_s;

  crypto_byte_path u_byte_path (
    .din   (in_data),
    .mode  (mode_eff_s),
    .xform (xform_s),
    .hash_c(hash_s)
  );

  // Per-byte control: effective mode, next count/accumulator, last/truncation and handshakes.
  always_comb begin
    // The first byte of a frame uses the live mode pin; later bytes use the latched copy.
    mode_eff_s  = (state_r == IDLE) ? mode : mode_r;
    cnt_nxt_s   = (state_r == IDLE) ? 16'd1 : (cnt_r + 16'd1);
    acc_prev_s  = (state_r == IDLE) ? SEED : acc_r;
    acc_nxt_s   = dig_step(acc_prev_s, hash_s);
    last_s      = in_last || (cnt_nxt_s == MAX_LEN_C);
    trunc_s     = (cnt_nxt_s == MAX_LEN_C) && !in_last;
    // out_ready feeds in_ready combinationally so the output register can refill every cycle.
    in_ready_s  = (state_r != DIGEST) && (!out_valid_r || out_ready);
    accept_s    = in_valid && in_ready_s;
    // Holding the digest back while a data byte is pending keeps it behind the last byte.
    dig_valid_s = (state_r == DIGEST) && !out_valid_r;
    dig_hs_s    = dig_valid_s && dig_ready;
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, STREAM: begin
        if (accept_s) begin
          state_nxt_s = last_s ? DIGEST : STREAM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DIGEST: begin
        if (dig_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DIGEST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame bookkeeping: latched mode, running digest, byte count, frozen digest and trunc flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r   <= MODE_ENC;
      acc_r    <= SEED;
      cnt_r    <= 16'd0;
      digest_r <= 8'h00;
      trunc_r  <= 1'b0;
    end else if (accept_s) begin
      mode_r <= mode_eff_s;
      acc_r  <= acc_nxt_s;
      cnt_r  <= cnt_nxt_s;
      if (last_s) begin
        digest_r <= acc_nxt_s;
        trunc_r  <= trunc_s;
      end else begin
        digest_r <= digest_r;
        trunc_r  <= trunc_r;
      end
    end else if (dig_hs_s) begin
      acc_r <= SEED;
      cnt_r <= 16'd0;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Output register: load on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= xform_s;
      out_last_r  <= last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign dig_valid = dig_valid_s;
  assign digest    = digest_r;
  assign dig_trunc = trunc_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_crypto_frame_ctrl.sv
// Testbench for crypto_frame_ctrl: directed frames plus randomized traffic, with a
// queue-based scoreboard filled at input acceptance and drained by an output monitor.
module tb_crypto_frame_ctrl;

  localparam logic [7:0] SEED    = 8'h3A;
  localparam int         MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       dig_valid;
  logic       dig_ready = 1'b1;
  logic [7:0] digest;
  logic       dig_trunc;
  logic       busy;

  always #5 clk = ~clk;

  crypto_frame_ctrl #(.SEED(SEED), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .dig_trunc(dig_trunc),
    .busy(busy)
  );

  typedef struct { logic [7:0] d; logic l; } ob_t;
  typedef struct { logic [7:0] d; logic t; } db_t;

  ob_t out_q[$];
  db_t dig_q[$];
  int  total = 0;
  int  bad = 0;
  int  rdy_mode = 0;  // 0: always ready, 1: random ready, 2: out_ready held low
  logic [7:0] last_out = 8'h00, last_dig = 8'h00;
  logic       last_trunc = 1'b0;

  // Reference model state: one frame at a time, driven by accepted bytes.
  bit         m_in_frame = 1'b0;
  int         m_mode = 0, m_acc = 0, m_n = 0;

  // Monitor hold-tracking.
  bit         hold_o = 1'b0, hold_d = 1'b0;
  logic [7:0] p_data = 8'h00, p_dig = 8'h00;
  logic       p_last = 1'b0;

  function automatic int m_enc(int x);
    int t;
    t = x ^ 'h3C;
    return ((t * 8) % 256) + t / 32;
  endfunction

  function automatic int m_dec(int y);
    return ((y / 8) + (y % 8) * 32) ^ 'h3C;
  endfunction

  function automatic int m_hash(int x);
    return ((x ^ 'hA7) + (x % 16) * 16 + x / 16) % 256;
  endfunction

  function automatic int m_fold(int acc, int h);
    return (((acc * 2) % 256) + acc / 128) ^ h;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(input int d, input bit l, input bit m,
                              output logic [7:0] ex, output logic el);
    int c;
    ob_t o;
    db_t g;
    if (!m_in_frame) begin
      m_in_frame = 1'b1;
      m_mode = m;
      m_acc = SEED;
      m_n = 0;
    end
    m_n++;
    c = (m_mode == 1) ? d : m_enc(d);
    ex = 8'((m_mode == 1) ? m_dec(d) : m_enc(d));
    m_acc = m_fold(m_acc, m_hash(c));
    el = l || (m_n == MAX_LEN);
    o.d = ex;
    o.l = el;
    out_q.push_back(o);
    if (el) begin
      g.d = 8'(m_acc);
      g.t = (m_n == MAX_LEN) && !l;
      dig_q.push_back(g);
      m_in_frame = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit l, input bit m);
    int guard;
    bit ok;
    logic [7:0] ex;
    logic el;
    guard = 0;
    ok = 1'b0;
    in_data = d;
    in_last = l;
    mode = m;
    in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        guard++;
        if (guard > 200) begin
          chk("accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    model_accept(d, l, m, ex, el);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, ex);
    chk("lat_last", out_last, el);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((out_q.size() != 0 || dig_q.size() != 0) && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_pending", out_q.size() + dig_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: drives sink readiness, pops the scoreboard on each output handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin out_ready = 1'b1; dig_ready = 1'b1; end
        1: begin
          out_ready = ($urandom_range(0, 3) != 0);
          dig_ready = ($urandom_range(0, 2) != 0);
        end
        default: begin out_ready = 1'b0; dig_ready = 1'b1; end
      endcase
      @(negedge clk);
      if (rst) begin
        hold_o = 1'b0;
        hold_d = 1'b0;
      end else begin
        if (hold_o) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", {out_last, out_data}, {p_last, p_data});
        end
        if (hold_d) begin
          chk("hold_dig_valid", dig_valid, 1);
          chk("hold_digest", digest, p_dig);
        end
        if (out_valid || dig_valid) chk("busy_active", busy, 1);
        if (dig_valid) chk("dig_before_data", out_valid, 0);
        if (out_valid && out_ready) begin
          if (out_q.size() == 0) begin
            chk("out_unexpected", 32'd1, 32'd0);
          end else begin
            ob_t e;
            e = out_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            last_out = out_data;
          end
        end
        if (dig_valid && dig_ready) begin
          if (dig_q.size() == 0) begin
            chk("dig_unexpected", 32'd1, 32'd0);
          end else begin
            db_t e;
            e = dig_q.pop_front();
            chk("digest", digest, e.d);
            chk("dig_trunc", dig_trunc, e.t);
            last_dig = digest;
            last_trunc = dig_trunc;
          end
        end
        hold_o = out_valid && !out_ready;
        p_data = out_data;
        p_last = out_last;
        hold_d = dig_valid && !dig_ready;
        p_dig  = digest;
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_dig_valid"}, dig_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_digest"}, digest, 0);
    chk({tag, "_dig_trunc"}, dig_trunc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int a;
    int len;
    logic [7:0] d2, o2;
    logic [7:0] t4 [6];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Encrypt 3-byte frame
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    drain();
    a = SEED;
    a = m_fold(a, m_hash(m_enc('h00)));
    a = m_fold(a, m_hash(m_enc('h5A)));
    a = m_fold(a, m_hash(m_enc('hFF)));
    chk("t1_digest", last_dig, a);
    chk("t1_trunc", last_trunc, 0);
    chk("t1_idle_busy", busy, 0);

    // Decrypt 1-byte frame, then round trip through encrypt
    send_byte(8'hA5, 1'b1, 1'b1);
    drain();
    chk("t2_out", last_out, m_dec('hA5));
    chk("t2_digest", last_dig, m_fold(SEED, m_hash('hA5)));
    d2 = last_dig;
    o2 = last_out;
    send_byte(o2, 1'b1, 1'b0);
    drain();
    chk("rt_out", last_out, 8'hA5);
    chk("rt_digest", last_dig, d2);

    // Back-pressure for 4 cycles mid-frame
    send_byte(8'h10, 1'b0, 1'b0);
    rdy_mode = 2;
    out_ready = 1'b0;
    in_data = 8'h20;
    in_last = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, m_enc('h10));
      chk("bp_dig_valid", dig_valid, 0);
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h30, 1'b1, 1'b0);
    drain();

    // Truncation at MAX_LEN, then the remaining 2 bytes as a second frame
    for (int i = 0; i < 6; i++) t4[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_byte(t4[i], 1'b0, 1'b0);
    drain();
    a = SEED;
    for (int i = 0; i < 4; i++) a = m_fold(a, m_hash(m_enc(int'(t4[i]))));
    chk("t4_trunc", last_trunc, 1);
    chk("t4_digest", last_dig, a);
    send_byte(t4[4], 1'b0, 1'b0);
    send_byte(t4[5], 1'b1, 1'b0);
    drain();
    a = m_fold(m_fold(SEED, m_hash(m_enc(int'(t4[4])))), m_hash(m_enc(int'(t4[5]))));
    chk("t4b_trunc", last_trunc, 0);
    chk("t4b_digest", last_dig, a);

    // Mode toggled mid-frame: latched decrypt must persist
    send_byte(8'h3C, 1'b0, 1'b1);
    chk("t5_busy", busy, 1);
    send_byte(8'h7E, 1'b0, 1'b0);
    chk("t5_out_latched", out_data, m_dec('h7E));
    send_byte(8'hC3, 1'b1, 1'b0);
    drain();
    chk("t5_digest", last_dig,
        m_fold(m_fold(m_fold(SEED, m_hash('h3C)), m_hash('h7E)), m_hash('hC3)));

    // Reset during STREAM after 2 bytes
    send_byte(8'hDE, 1'b0, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    out_q.delete();
    dig_q.delete();
    m_in_frame = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0);
    drain();
    chk("t6_digest", last_dig, m_fold(SEED, m_hash(m_enc('h11))));
    chk("t6_trunc", last_trunc, 0);

    // Randomized frames with random sink readiness and mode changes
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        send_byte(8'($urandom_range(0, 255)), (i == len - 1), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode = 0;
    drain();
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
